// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states and grant types.
// Also imported by the sdram_read / sdram_write / sdram_aref client blocks.
package sdram_pkg;

    localparam int ADDR_W_DEF = 12;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } arb_state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

    // On a write/read tie the client that did not win last time goes next.
    function automatic grant_t tie_winner(input grant_t last);
        return (last == GNT_READ) ? GNT_WRITE : GNT_READ;
    endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// Client handshakes (init, refresh, write, read) and the arbitrated SDRAM command bus.
// slave: the arbiter side; master: the client/pad side that drives requests.
interface sdram_arbit_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_bank;
    logic              wr_en;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_bank;
    logic              rd_en;

    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [1:0]        sdram_bank;
    logic              arb_busy;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cmd, sdram_addr, sdram_bank, arb_busy
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output aref_req, aref_end, aref_cmd, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cmd, sdram_addr, sdram_bank, arb_busy
    );

endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: waits for init, then grants refresh/write/read one at a time
// and muxes the owning client's command onto the SDRAM bus.
//
// state   | meaning
// S_INIT  | power-up sequence owns the bus; requests ignored until init_end
// S_ARBIT | idle, NOP on bus; picks refresh > (write/read, alternating on tie)
// S_AREF  | refresh client owns the bus until aref_end
// S_WRITE | write client owns the bus until wr_end
// S_READ  | read client owns the bus until rd_end
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic          sclk,
    input  logic          rst_n,
    sdram_arbit_if.slave  bus
);

    arb_state_t state;
    arb_state_t state_nxt;
    grant_t     last_grant;
    grant_t     last_grant_nxt;

    logic aref_en_q;
    logic wr_en_q;
    logic rd_en_q;
    logic aref_en_nxt;
    logic wr_en_nxt;
    logic rd_en_nxt;
    logic cke_q;

    logic [3:0]        cmd_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [1:0]        bank_mux;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            last_grant <= GNT_READ;
            aref_en_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            cke_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            aref_en_q  <= aref_en_nxt;
            wr_en_q    <= wr_en_nxt;
            rd_en_q    <= rd_en_nxt;
            cke_q      <= 1'b1;
        end
    end

    // The en strobes are registered alongside the state so they mark the first owned cycle.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        aref_en_nxt    = 1'b0;
        wr_en_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        case (state)
            S_INIT: begin
                if (bus.init_end) state_nxt = S_ARBIT;
            end
            S_ARBIT: begin
                if (bus.aref_req) begin
                    state_nxt   = S_AREF;
                    aref_en_nxt = 1'b1;
                end else if (bus.wr_req &&
                             (!bus.rd_req || tie_winner(last_grant) == GNT_WRITE)) begin
                    state_nxt      = S_WRITE;
                    wr_en_nxt      = 1'b1;
                    last_grant_nxt = GNT_WRITE;
                end else if (bus.rd_req) begin
                    state_nxt      = S_READ;
                    rd_en_nxt      = 1'b1;
                    last_grant_nxt = GNT_READ;
                end
            end
            S_AREF: begin
                if (bus.aref_end) state_nxt = S_ARBIT;
            end
            S_WRITE: begin
                if (bus.wr_end) state_nxt = S_ARBIT;
            end
            S_READ: begin
                if (bus.rd_end) state_nxt = S_ARBIT;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        bank_mux = 2'b00;
        case (state)
            S_INIT: begin
                cmd_mux  = bus.init_cmd;
                addr_mux = bus.init_addr;
            end
            S_AREF: begin
                cmd_mux  = bus.aref_cmd;
                addr_mux = bus.aref_addr;
            end
            S_WRITE: begin
                cmd_mux  = bus.wr_cmd;
                addr_mux = bus.wr_addr;
                bank_mux = bus.wr_bank;
            end
            S_READ: begin
                cmd_mux  = bus.rd_cmd;
                addr_mux = bus.rd_addr;
                bank_mux = bus.rd_bank;
            end
            default: ;
        endcase
    end

    assign bus.aref_en    = aref_en_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.sdram_cke  = cke_q;
    assign bus.sdram_cmd  = cmd_mux;
    assign bus.sdram_addr = addr_mux;
    assign bus.sdram_bank = bank_mux;
    assign bus.arb_busy   = (state == S_AREF) || (state == S_WRITE) || (state == S_READ);

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: an ownership-level model checked every cycle,
// plus literal expectations on grant order, latency and asynchronous reset.
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int AW = 12;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    sdram_arbit_if #(.ADDR_W(AW)) bus ();

    sdram_arbit #(.ADDR_W(AW)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, whether init has completed, who last won a write/read grant.
    typedef enum int {OWN_NONE, OWN_AREF, OWN_WR, OWN_RD} owner_t;
    bit     m_ready;
    bit     m_cke;
    bit     m_last_wr;
    owner_t m_owner;
    owner_t m_pulse;

    function automatic owner_t pick(input bit a, input bit w, input bit r, input bit last_wr);
        if (a) return OWN_AREF;
        if (w && r) return last_wr ? OWN_RD : OWN_WR;
        if (w) return OWN_WR;
        if (r) return OWN_RD;
        return OWN_NONE;
    endfunction

    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready   <= 1'b0;
            m_cke     <= 1'b0;
            m_last_wr <= 1'b0;
            m_owner   <= OWN_NONE;
            m_pulse   <= OWN_NONE;
        end else begin
            m_cke   <= 1'b1;
            m_pulse <= OWN_NONE;
            if (!m_ready) begin
                m_ready <= bus.init_end;
            end else if (m_owner == OWN_NONE) begin
                m_owner <= pick(bus.aref_req, bus.wr_req, bus.rd_req, m_last_wr);
                m_pulse <= pick(bus.aref_req, bus.wr_req, bus.rd_req, m_last_wr);
                if (!bus.aref_req && (bus.wr_req || bus.rd_req))
                    m_last_wr <= (pick(1'b0, bus.wr_req, bus.rd_req, m_last_wr) == OWN_WR);
            end else if ((m_owner == OWN_AREF && bus.aref_end) ||
                         (m_owner == OWN_WR   && bus.wr_end)   ||
                         (m_owner == OWN_RD   && bus.rd_end)) begin
                m_owner <= OWN_NONE;
            end
        end
    end

    function automatic logic [22:0] model_out();
        logic [3:0]    c;
        logic [AW-1:0] a;
        logic [1:0]    b;
        c = CMD_NOP;
        a = '0;
        b = 2'b00;
        if (!m_ready) begin
            c = bus.init_cmd;
            a = bus.init_addr;
        end else begin
            case (m_owner)
                OWN_AREF: begin c = bus.aref_cmd; a = bus.aref_addr; end
                OWN_WR:   begin c = bus.wr_cmd;   a = bus.wr_addr;   b = bus.wr_bank; end
                OWN_RD:   begin c = bus.rd_cmd;   a = bus.rd_addr;   b = bus.rd_bank; end
                default:  ;
            endcase
        end
        return {m_cke, (m_owner != OWN_NONE), (m_pulse == OWN_AREF), (m_pulse == OWN_WR),
                (m_pulse == OWN_RD), c, a, b};
    endfunction

    function automatic logic [22:0] dut_out();
        return {bus.sdram_cke, bus.arb_busy, bus.aref_en, bus.wr_en, bus.rd_en,
                bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank};
    endfunction

    initial begin
        forever begin
            @(negedge sclk);
            check("cycle_outputs", 64'(dut_out()), 64'(model_out()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Returns 'A'/'W'/'R' for the first en pulse seen, 'T' if none within the budget.
    task automatic wait_en(output byte who, output int cyc);
        who = "T";
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge sclk);
            #1;
            if (bus.aref_en || bus.wr_en || bus.rd_en) begin
                who = bus.aref_en ? "A" : (bus.wr_en ? "W" : "R");
                cyc = i;
                break;
            end
        end
    endtask

    task automatic count_en(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.aref_en || bus.wr_en || bus.rd_en) pulses++;
        end
    endtask

    task automatic end_pulse(input byte who, input bit keep_req);
        if (who == "A") begin bus.aref_end = 1'b1; if (!keep_req) bus.aref_req = 1'b0; end
        if (who == "W") begin bus.wr_end   = 1'b1; if (!keep_req) bus.wr_req   = 1'b0; end
        if (who == "R") begin bus.rd_end   = 1'b1; if (!keep_req) bus.rd_req   = 1'b0; end
        tick(1);
        bus.aref_end = 1'b0;
        bus.wr_end   = 1'b0;
        bus.rd_end   = 1'b0;
    endtask

    initial begin
        byte          who;
        int           cyc;
        int           pulses;
        logic [47:0]  seq;
        logic [47:0]  seq_exp;

        bus.init_end  = 1'b0; bus.init_cmd = CMD_PRE;  bus.init_addr = 12'h400;
        bus.aref_req  = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = CMD_AREF; bus.aref_addr = 12'h011;
        bus.wr_req    = 1'b0; bus.wr_end   = 1'b0; bus.wr_cmd   = CMD_WR;   bus.wr_addr   = 12'h123;
        bus.wr_bank   = 2'b10;
        bus.rd_req    = 1'b0; bus.rd_end   = 1'b0; bus.rd_cmd   = CMD_ACT;  bus.rd_addr   = 12'h2A5;
        bus.rd_bank   = 2'b11;

        tick(3);
        check("reset_cke", bus.sdram_cke, 0);
        check("reset_cmd", bus.sdram_cmd, CMD_PRE);
        rst_n = 1'b1;
        tick(1);
        check("cke_after_release", bus.sdram_cke, 1);

        // Requests while init is pending are ignored.
        bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        count_en(50, pulses);
        check("no_grant_in_init", pulses, 0);
        check("init_cmd_on_bus", bus.sdram_cmd, CMD_PRE);
        check("init_addr_on_bus", bus.sdram_addr, 12'h400);

        bus.init_end = 1'b1;
        tick(1);
        check("arbit_nop", bus.sdram_cmd, CMD_NOP);
        check("arbit_idle", bus.arb_busy, 0);
        tick(1);
        check("first_grant_aref", bus.aref_en, 1);
        check("aref_cmd_on_bus", bus.sdram_cmd, CMD_AREF);

        // Three-way request: aref, then write (wins first tie), then read.
        tick(2);
        check("aref_en_width", bus.aref_en, 0);
        end_pulse("A", 1'b0);
        wait_en(who, cyc);
        check("after_aref_grant", who, "W");
        check("gap_after_aref", cyc, 1);
        tick(1);
        end_pulse("W", 1'b0);
        wait_en(who, cyc);
        check("after_wr_grant", who, "R");
        check("gap_after_wr", cyc, 1);
        tick(1);
        end_pulse("R", 1'b0);

        // Alternation under sustained write/read contention.
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        seq = '0;
        for (int g = 0; g < 6; g++) begin
            wait_en(who, cyc);
            seq = {seq[39:0], who};
            tick(1);
            check("en_one_cycle", {bus.aref_en, bus.wr_en, bus.rd_en}, 3'b000);
            end_pulse(who, 1'b1);
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        seq_exp = "WRWRWR";
        check("alternation_order", seq, seq_exp);

        // Read mux and immunity to a stray write end.
        bus.rd_cmd = CMD_RD; bus.rd_addr = 12'h0FC; bus.rd_bank = 2'b01;
        tick(1);
        bus.rd_req = 1'b1;
        wait_en(who, cyc);
        check("read_granted", who, "R");
        check("read_cmd", bus.sdram_cmd, 4'b0101);
        check("read_addr", bus.sdram_addr, 12'h0FC);
        check("read_bank", bus.sdram_bank, 2'b01);
        end_pulse("W", 1'b1);
        check("stray_wr_end_busy", bus.arb_busy, 1);
        check("stray_wr_end_cmd", bus.sdram_cmd, 4'b0101);

        // Refresh request during a read waits; read ends, re-requests, is re-granted.
        bus.aref_req = 1'b1;
        tick(2);
        check("no_preempt", bus.sdram_cmd, CMD_RD);
        end_pulse("R", 1'b1);
        wait_en(who, cyc);
        check("aref_before_reread", who, "A");
        tick(1);
        end_pulse("A", 1'b0);
        wait_en(who, cyc);
        check("reread_granted", who, "R");
        tick(1);
        end_pulse("R", 1'b0);

        // Refresh between a read and a tie must not disturb the alternation.
        bus.aref_req = 1'b1;
        wait_en(who, cyc);
        check("aref_alone", who, "A");
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        end_pulse("A", 1'b0);
        wait_en(who, cyc);
        check("tie_after_aref", who, "W");

        // Asynchronous reset in the first write cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_en", bus.wr_en, 0);
        check("async_rst_cke", bus.sdram_cke, 0);
        check("async_rst_busy", bus.arb_busy, 0);
        check("async_rst_cmd", bus.sdram_cmd, CMD_PRE);
        bus.init_end = 1'b0;
        tick(2);
        rst_n = 1'b1;
        count_en(10, pulses);
        check("no_grant_after_reset", pulses, 0);
        bus.init_end = 1'b1;
        wait_en(who, cyc);
        check("grant_after_reinit", who, "W");
        check("reinit_latency", cyc, 2);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        tick(1);
        end_pulse("W", 1'b0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter: ADDR_W, 12, SDRAM address bus width.
REQ-002 SHALL have port: sclk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: init_end input 1 (initialisation complete, level); init_cmd input 4; init_addr input ADDR_W.
REQ-005 SHALL have ports: aref_req input 1; aref_end input 1 (one-cycle pulse); aref_cmd input 4; aref_addr input ADDR_W; aref_en output 1.
REQ-006 SHALL have ports: wr_req input 1; wr_end input 1 (one-cycle pulse); wr_cmd input 4; wr_addr input ADDR_W; wr_bank input 2; wr_en output 1.
REQ-007 SHALL have ports: rd_req input 1; rd_end input 1 (one-cycle pulse); rd_cmd input 4; rd_addr input ADDR_W; rd_bank input 2; rd_en output 1.
REQ-008 SHALL have ports: sdram_cke output 1; sdram_cmd output 4 {cs_n,ras_n,cas_n,we_n}; sdram_addr output ADDR_W; sdram_bank output 2; arb_busy output 1.

Function
REQ-009 SHALL implement a one-hot FSM with states S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ.
REQ-010 S_INIT SHALL move to S_ARBIT on the first edge with init_end=1; all requests are ignored until then.
REQ-011 S_ARBIT SHALL grant at most one client per edge; aref_req has absolute priority over wr_req and rd_req.
REQ-012 When wr_req and rd_req are both 1 without aref_req, the grant SHALL go to the client not granted last (last_grant register, reset to READ, so write wins the first tie).
REQ-013 A lone wr_req or rd_req SHALL be granted regardless of last_grant.
REQ-014 On a grant, state SHALL enter S_AREF/S_WRITE/S_READ, and the matching en output SHALL be a single-cycle registered pulse, high in the first cycle of the new state.
REQ-015 S_AREF SHALL return to S_ARBIT on aref_end, S_WRITE on wr_end, and S_READ on rd_end; end pulses from non-active clients SHALL be ignored.
REQ-016 last_grant SHALL update only on wr/rd grants; refresh grants leave it unchanged.
REQ-017 A client interrupted by refresh (end pulse, then re-request) SHALL be re-arbitrated normally; no preemption exists inside S_WRITE/S_READ.
REQ-018 Minimum gap SHALL be one S_ARBIT cycle between any *_end and the next en pulse.
REQ-019 sdram_cmd/addr/bank SHALL be a combinational mux on state: S_INIT init_*, bank 00; S_AREF aref_*, bank 00; S_WRITE wr_*; S_READ rd_*; S_ARBIT NOP 4'b0111, addr 0, bank 00.
REQ-020 sdram_cke SHALL be constant 1 after reset release and 0 during reset.
REQ-021 arb_busy SHALL be 1 in S_AREF, S_WRITE, and S_READ, and 0 otherwise.
REQ-022 An illegal state encoding SHALL recover to S_INIT on the next edge.

Reset
REQ-023 rst_n low SHALL asynchronously force: state S_INIT, aref_en/wr_en/rd_en 0, last_grant READ, sdram_cke 0, arb_busy 0; sdram_cmd/addr/bank then follow init_* with bank 00.
REQ-024 Reset asserted mid-transfer SHALL abandon the grant immediately; after release the full init handshake is required again.

Structure
REQ-025 Command encodings (NOP 0111, PRE 0010, AREF 0001, ACT 0011, RD 0101, WR 0100, MRS 0000), state encodings, and ADDR_W default SHALL reside in shared package sdram_pkg, also used by sdram_read/sdram_write/sdram_aref.
REQ-026 No sub-module is required; FSM, grant logic, and output mux SHALL reside in sdram_arbit.

Verification
REQ-027 init_end=0 with aref_req/wr_req/rd_req=1 for 50 cycles -> no en pulse, sdram_cmd=init_cmd; raise init_end -> S_ARBIT next edge, aref_en pulse next.
REQ-028 Same-cycle aref_req=wr_req=rd_req=1 in S_ARBIT -> aref_en only; after aref_end -> wr_en; after wr_end -> rd_en.
REQ-029 wr_req and rd_req held high for 6 grants -> grant order W,R,W,R,W,R; each en exactly 1 cycle wide.
REQ-030 In S_READ, rd_cmd=0101, rd_addr=0x0FC -> sdram_cmd=0101, sdram_addr=0x0FC same cycle; stray wr_end pulse -> state stays S_READ.
REQ-031 rd_end caused by aref_req mid-read, rd_req reasserted -> aref granted first, read re-granted after aref_end, last_grant unchanged by refresh.
REQ-032 rst_n low during S_WRITE -> wr_en 0, sdram_cke 0, state S_INIT without waiting for a clock edge.
